divide_scheduler: RTL and testbench

//  Shares one Divider datapath between two requesters (port 0, port 1) using round-robin arbitration.

---
 rtl/divide_scheduler_pkg.sv | 12 +
 rtl/rr_arbiter_2.sv | 22 ++
 rtl/divide_scheduler.sv | 118 +++++++++++
 tb/tb_divide_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divide_scheduler_pkg.sv
// Shared types for the divide scheduler: FSM state encoding and requester count.
// Optional feature macro used by the top: DIVIDE_SCHEDULER_ZERO_BYPASS_EN.
package divide_scheduler_pkg;
  localparam int PORTS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester wins; on contention the port
// that did not win last time is granted.
module rr_arbiter_2
  import divide_scheduler_pkg::*;
(
  input  logic [PORTS-1:0] req,
  input  logic             last_grant,
  output logic             grant_valid,
  output logic             grant
);

  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    if (req[0] && req[1]) begin
      grant = ~last_grant;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/divide_scheduler.sv
// Shares one multi-cycle Divider between two requesters with round-robin arbitration.
// Define DIVIDE_SCHEDULER_ZERO_BYPASS_EN to answer divide-by-zero without running the Divider.
module divide_scheduler
  import divide_scheduler_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [PORTS-1:0]   i_req_valid,
  output logic [PORTS-1:0]   o_req_ready,
  input  logic [PORTS*N-1:0] i_req_dividend,
  input  logic [PORTS*N-1:0] i_req_divisor,
  output logic [PORTS-1:0]   o_resp_valid,
  input  logic [PORTS-1:0]   i_resp_ready,
  output logic [N-1:0]       o_resp_quotient,
  output logic [N-1:0]       o_resp_remainder,
  output logic               o_resp_undefined,
  output logic               o_busy,
  output logic               o_div_start,
  output logic [N-1:0]       o_div_dividend,
  output logic [N-1:0]       o_div_divisor,
  input  logic               i_div_finished,
  input  logic [N-1:0]       i_div_quotient,
  input  logic [N-1:0]       i_div_remainder,
  input  logic               i_div_undefined
);

  state_t         state_reg, state_next;
  logic           owner_reg;
  logic           last_grant_reg;
  logic [N-1:0]   dividend_reg, divisor_reg;
  logic [N-1:0]   quotient_reg, remainder_reg;
  logic           undefined_reg;

  logic           grant_valid, grant;
  logic           accept;
  logic           bypass;
  logic [N-1:0]   sel_dividend, sel_divisor;

  rr_arbiter_2 u_arb (
    .req         (i_req_valid),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign accept       = (state_reg == IDLE) && grant_valid;
  assign sel_dividend = grant ? i_req_dividend[2*N-1:N] : i_req_dividend[N-1:0];
  assign sel_divisor  = grant ? i_req_divisor[2*N-1:N]  : i_req_divisor[N-1:0];

`ifdef DIVIDE_SCHEDULER_ZERO_BYPASS_EN
  assign bypass = (sel_divisor == '0);
`else
  assign bypass = 1'b0;
`endif

  // Ready is gated by reset so every output reads 0 while reset is held.
  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      assign o_req_ready[gi]  = !i_reset && accept && (grant == 1'(gi));
      assign o_resp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = bypass ? RESP : START;
      START:   state_next = BUSY;
      BUSY:    if (i_div_finished) state_next = RESP;
      RESP:    if (i_resp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      dividend_reg   <= '0;
      divisor_reg    <= '0;
      quotient_reg   <= '0;
      remainder_reg  <= '0;
      undefined_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        dividend_reg   <= sel_dividend;
        divisor_reg    <= sel_divisor;
        owner_reg      <= grant;
        last_grant_reg <= grant;
        if (bypass) begin
          quotient_reg  <= '1;
          remainder_reg <= sel_dividend;
          undefined_reg <= 1'b1;
        end
      end
      if ((state_reg == BUSY) && i_div_finished) begin
        quotient_reg  <= i_div_quotient;
        remainder_reg <= i_div_remainder;
        undefined_reg <= i_div_undefined;
      end
    end
  end

  // Operands stay on the Divider bus until the response is taken, since it reloads each clock.
  assign o_div_dividend   = dividend_reg;
  assign o_div_divisor    = divisor_reg;
  assign o_div_start      = (state_reg == START);
  assign o_busy           = (state_reg != IDLE);
  assign o_resp_quotient  = quotient_reg;
  assign o_resp_remainder = remainder_reg;
  assign o_resp_undefined = undefined_reg;

endmodule

// File: tb/tb_divide_scheduler.sv
// Directed bench for divide_scheduler with a behavioural N-cycle Divider model.
module tb_divide_scheduler;
  localparam int N = 8;

`ifdef DIVIDE_SCHEDULER_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = N + 2;
`endif

  logic           i_clock = 1'b0;
  logic           i_reset;
  logic [1:0]     i_req_valid;
  logic [1:0]     o_req_ready;
  logic [2*N-1:0] i_req_dividend;
  logic [2*N-1:0] i_req_divisor;
  logic [1:0]     o_resp_valid;
  logic [1:0]     i_resp_ready;
  logic [N-1:0]   o_resp_quotient;
  logic [N-1:0]   o_resp_remainder;
  logic           o_resp_undefined;
  logic           o_busy;
  logic           o_div_start;
  logic [N-1:0]   o_div_dividend;
  logic [N-1:0]   o_div_divisor;
  logic           i_div_finished;
  logic [N-1:0]   i_div_quotient;
  logic [N-1:0]   i_div_remainder;
  logic           i_div_undefined;

  divide_scheduler #(.N(N)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_dividend   (i_req_dividend),
    .i_req_divisor    (i_req_divisor),
    .o_resp_valid     (o_resp_valid),
    .i_resp_ready     (i_resp_ready),
    .o_resp_quotient  (o_resp_quotient),
    .o_resp_remainder (o_resp_remainder),
    .o_resp_undefined (o_resp_undefined),
    .o_busy           (o_busy),
    .o_div_start      (o_div_start),
    .o_div_dividend   (o_div_dividend),
    .o_div_divisor    (o_div_divisor),
    .i_div_finished   (i_div_finished),
    .i_div_quotient   (i_div_quotient),
    .i_div_remainder  (i_div_remainder),
    .i_div_undefined  (i_div_undefined)
  );

  always #5 i_clock = ~i_clock;

  // Divider model: finished rises N cycles after the start pulse cycle.
  logic model_run;
  int   model_cnt;
  logic inject_fin;
  int   start_count = 0;

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      model_run <= 1'b0;
      model_cnt <= 0;
    end else if (o_div_start) begin
      model_run <= 1'b1;
      model_cnt <= N - 1;
    end else if (model_run) begin
      if (model_cnt == 0) model_run <= 1'b0;
      else model_cnt <= model_cnt - 1;
    end
  end

  always @(posedge i_clock) begin
    if (o_div_start) start_count <= start_count + 1;
  end

  assign i_div_finished  = (model_run && model_cnt == 0) || inject_fin;
  assign i_div_quotient  = (o_div_divisor == 0) ? '1 : o_div_dividend / o_div_divisor;
  assign i_div_remainder = (o_div_divisor == 0) ? o_div_dividend : o_div_dividend % o_div_divisor;
  assign i_div_undefined = (o_div_divisor == 0);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_resp(input logic [1:0] exp);
    int cnt = 0;
    while (o_resp_valid == 2'b00 && cnt < 4 * N) begin
      @(negedge i_clock);
      cnt++;
    end
    check("resp_valid", {30'd0, o_resp_valid}, {30'd0, exp});
  endtask

  task automatic run_job(input int p, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r, input logic u,
                         input int exp_lat, input bit wiggle);
    int cnt;
    int s0;
    @(negedge i_clock);
    s0 = start_count;
    i_req_valid[p] = 1'b1;
    i_req_dividend[p*N +: N] = a;
    i_req_divisor[p*N +: N]  = b;
    #1 check($sformatf("p%0d req_ready", p), {30'd0, o_req_ready}, 32'd1 << p);
    @(posedge i_clock);
    @(negedge i_clock);
    i_req_valid[p] = 1'b0;
    cnt = 1;
    while (o_resp_valid == 2'b00 && cnt < 4 * N) begin
      if (wiggle) begin
        i_req_divisor  = 16'($urandom);
        i_req_dividend = 16'($urandom);
        #1;
        check("div_divisor held", {24'd0, o_div_divisor}, {24'd0, b});
        check("div_dividend held", {24'd0, o_div_dividend}, {24'd0, a});
      end
      @(negedge i_clock);
      cnt++;
    end
    check($sformatf("%0d/%0d latency", a, b), cnt, exp_lat);
    check($sformatf("%0d/%0d resp_valid", a, b), {30'd0, o_resp_valid}, 32'd1 << p);
    check($sformatf("%0d/%0d quotient", a, b), {24'd0, o_resp_quotient}, {24'd0, q});
    check($sformatf("%0d/%0d remainder", a, b), {24'd0, o_resp_remainder}, {24'd0, r});
    check($sformatf("%0d/%0d undefined", a, b), {31'd0, o_resp_undefined}, {31'd0, u});
    check($sformatf("%0d/%0d start pulses", a, b), start_count - s0, (exp_lat == 1) ? 0 : 1);
    i_resp_ready[p] = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_resp_ready[p] = 1'b0;
    check("idle after resp", {31'd0, o_busy}, 32'd0);
    check("resp dropped", {30'd0, o_resp_valid}, 32'd0);
    $display("[TB] job p%0d %0d/%0d -> q=%0d r=%0d u=%0d lat=%0d", p, a, b,
             o_resp_quotient, o_resp_remainder, o_resp_undefined, cnt);
  endtask

  typedef struct {
    int           port;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         u;
  } vec_t;

  vec_t vecs[6];
  bit   saw_resp;

  initial begin
    vecs[0] = '{0, 8'd200, 8'd7,  8'd28, 8'd4,  1'b0};
    vecs[1] = '{1, 8'd100, 8'd10, 8'd10, 8'd0,  1'b0};
    vecs[2] = '{0, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0};
    vecs[3] = '{1, 8'd5,   8'd9,  8'd0,  8'd5,  1'b0};
    vecs[4] = '{0, 8'd1,   8'd1,  8'd1,  8'd0,  1'b0};
    vecs[5] = '{1, 8'd9,   8'd3,  8'd3,  8'd0,  1'b0};

    i_reset        = 1'b1;
    i_req_valid    = 2'b11;
    i_req_dividend = '0;
    i_req_divisor  = '0;
    i_resp_ready   = 2'b00;
    inject_fin     = 1'b0;
    repeat (3) @(negedge i_clock);
    check("reset req_ready", {30'd0, o_req_ready}, 32'd0);
    check("reset busy", {31'd0, o_busy}, 32'd0);
    check("reset resp_valid", {30'd0, o_resp_valid}, 32'd0);
    check("reset div_start", {31'd0, o_div_start}, 32'd0);
    check("reset div_dividend", {24'd0, o_div_dividend}, 32'd0);
    check("reset div_divisor", {24'd0, o_div_divisor}, 32'd0);
    check("reset quotient", {24'd0, o_resp_quotient}, 32'd0);
    check("reset undefined", {31'd0, o_resp_undefined}, 32'd0);
    i_req_valid = 2'b00;
    i_reset     = 1'b0;

    // Contention straight after reset: port 0 first, port 1 right after.
    @(negedge i_clock);
    i_req_valid    = 2'b11;
    i_req_dividend = {8'd50, 8'd20};
    i_req_divisor  = {8'd7, 8'd3};
    #1 check("contend ready p0", {30'd0, o_req_ready}, 32'd1);
    @(posedge i_clock);
    @(negedge i_clock);
    i_req_valid[0] = 1'b0;
    check("contend start", {31'd0, o_div_start}, 32'd1);
    check("contend ready busy", {30'd0, o_req_ready}, 32'd0);
    wait_resp(2'b01);
    check("contend p0 quotient", {24'd0, o_resp_quotient}, 32'd6);
    check("contend p0 remainder", {24'd0, o_resp_remainder}, 32'd2);
    check("contend ready resp", {30'd0, o_req_ready}, 32'd0);
    $display("[TB] contend p0 20/3 -> q=%0d r=%0d", o_resp_quotient, o_resp_remainder);
    i_resp_ready[0] = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_resp_ready[0] = 1'b0;
    check("contend ready p1", {30'd0, o_req_ready}, 32'd2);
    @(posedge i_clock);
    @(negedge i_clock);
    i_req_valid[1] = 1'b0;
    check("contend p1 start", {31'd0, o_div_start}, 32'd1);
    wait_resp(2'b10);
    check("contend p1 quotient", {24'd0, o_resp_quotient}, 32'd7);
    check("contend p1 remainder", {24'd0, o_resp_remainder}, 32'd1);
    $display("[TB] contend p1 50/7 -> q=%0d r=%0d", o_resp_quotient, o_resp_remainder);
    i_resp_ready[1] = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_resp_ready[1] = 1'b0;

    // Last winner was port 1, so contention now favours port 0; then withdraw.
    i_req_valid = 2'b11;
    #1 check("rr ready p0", {30'd0, o_req_ready}, 32'd1);
    i_req_valid = 2'b00;
    @(negedge i_clock);
    check("withdraw idle", {31'd0, o_busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].u, N + 2, i == 2);
    end

    // Port 1 stalls its response; result must hold and nothing else is accepted.
    @(negedge i_clock);
    i_req_valid[1] = 1'b1;
    i_req_dividend[15:8] = 8'd77;
    i_req_divisor[15:8]  = 8'd5;
    @(posedge i_clock);
    @(negedge i_clock);
    i_req_valid[1] = 1'b0;
    wait_resp(2'b10);
    i_req_valid[0] = 1'b1;
    i_req_dividend[7:0] = 8'd40;
    i_req_divisor[7:0]  = 8'd4;
    for (int k = 0; k < 5; k++) begin
      check("stall resp_valid", {30'd0, o_resp_valid}, 32'd2);
      check("stall quotient", {24'd0, o_resp_quotient}, 32'd15);
      check("stall remainder", {24'd0, o_resp_remainder}, 32'd2);
      check("stall req_ready", {30'd0, o_req_ready}, 32'd0);
      i_resp_ready[0] = 1'b1;
      @(negedge i_clock);
    end
    i_resp_ready[0] = 1'b0;
    i_req_valid[0]  = 1'b0;
    i_resp_ready[1] = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_resp_ready[1] = 1'b0;
    check("stall released", {31'd0, o_busy}, 32'd0);
    $display("[TB] stall p1 77/5 held 5 cycles");

    run_job(0, 8'd13, 8'd0, 8'hFF, 8'd13, 1'b1, ZLAT, 1'b0);

    // Stray finished while idle must not produce a response.
    @(negedge i_clock);
    inject_fin = 1'b1;
    @(negedge i_clock);
    inject_fin = 1'b0;
    check("stray finished busy", {31'd0, o_busy}, 32'd0);
    check("stray finished resp", {30'd0, o_resp_valid}, 32'd0);
    $display("[TB] stray finished in IDLE ignored");

    // Reset in the middle of a job abandons it.
    @(negedge i_clock);
    i_req_valid[0] = 1'b1;
    i_req_dividend[7:0] = 8'd100;
    i_req_divisor[7:0]  = 8'd7;
    @(posedge i_clock);
    @(negedge i_clock);
    i_req_valid[0] = 1'b0;
    repeat (3) @(negedge i_clock);
    check("midbusy busy", {31'd0, o_busy}, 32'd1);
    i_reset = 1'b1;
    #1;
    check("midreset busy", {31'd0, o_busy}, 32'd0);
    check("midreset resp_valid", {30'd0, o_resp_valid}, 32'd0);
    check("midreset req_ready", {30'd0, o_req_ready}, 32'd0);
    check("midreset div_start", {31'd0, o_div_start}, 32'd0);
    check("midreset div_dividend", {24'd0, o_div_dividend}, 32'd0);
    check("midreset div_divisor", {24'd0, o_div_divisor}, 32'd0);
    @(negedge i_clock);
    i_reset  = 1'b0;
    saw_resp = 1'b0;
    repeat (N + 4) begin
      @(negedge i_clock);
      if (o_resp_valid != 2'b00) saw_resp = 1'b1;
    end
    check("no resp after reset", {31'd0, saw_resp}, 32'd0);
    run_job(0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, N + 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
